bit_framer6: RTL and testbench

BIT_FRAMER6 -- requirements
Module: bit_framer6

---
 rtl/bit_framer6.sv | 126 ++++++++++++
 tb/tb_bit_framer6.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_framer6.sv
// rtl/bit_framer6.sv - serial-to-parallel word framer with single-entry output slot
module bit_framer6 #(
   parameter int WIDTH = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     bit_in,
   input  logic                     bit_valid,
   input  logic                     flush,
   input  logic                     clr_ovf,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         data_out,
   output logic                     data_valid,
   output logic [$clog2(WIDTH)-1:0] bit_cnt,
   output logic                     overflow,
   output logic [7:0]               word_cnt
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } slot_state_e;

   slot_state_e      state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       wcnt_q, wcnt_d;

   logic             accept;
   logic             complete;
   logic [WIDTH-1:0] word_new;
   logic             load;
   logic             drop;

   // A flush on the same edge as a bit discards that bit.
   assign accept   = bit_valid & ~flush;
   assign complete = accept && (cnt_q == CW'(WIDTH - 1));
   // MSB-first: the earliest bit ends up in the top position after WIDTH shifts.
   assign word_new = {sr_q[WIDTH-2:0], bit_in};

   // Output slot FSM: decide whether a completed word is loaded, dropped, or the slot drains.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      drop    = 1'b0;
      case (state_q)
         S_EMPTY: begin
            if (complete) begin
               load    = 1'b1;
               state_d = S_FULL;
            end
         end
         S_FULL: begin
            if (complete) begin
               if (out_ready) begin
                  load = 1'b1;
               end else begin
                  drop = 1'b1;
               end
            end else if (out_ready) begin
               state_d = S_EMPTY;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   // Shift register, bit counter, held word, sticky overflow and load counter next-state.
   always_comb begin
      sr_d   = sr_q;
      cnt_d  = cnt_q;
      data_d = data_q;
      ovf_d  = ovf_q;
      wcnt_d = wcnt_q;

      if (flush) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (bit_valid) begin
         sr_d  = word_new;
         cnt_d = complete ? '0 : cnt_q + 1'b1;
      end

      if (load) begin
         data_d = word_new;
         wcnt_d = wcnt_q + 8'd1;
      end

      // A drop on the same edge as a clear leaves the flag set.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   // State registers with asynchronous reset discarding all partial and held data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_EMPTY;
         sr_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
         wcnt_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = (state_q == S_FULL);
   assign bit_cnt    = cnt_q;
   assign overflow   = ovf_q;
   assign word_cnt   = wcnt_q;

endmodule

// File: tb/tb_bit_framer6.sv
// tb/tb_bit_framer6.sv - self-checking bench for bit_framer6 against a queue-based model
module tb_bit_framer6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       flush = 1'b0;
   logic       clr_ovf = 1'b0;
   logic       out_ready = 1'b0;
   logic [5:0] data_out;
   logic       data_valid;
   logic [2:0] bit_cnt;
   logic       overflow;
   logic [7:0] word_cnt;

   int checks = 0;
   int errors = 0;

   // reference model state
   int   m_bits[$];
   logic m_valid;
   int   m_data;
   logic m_ovf;
   int   m_wcnt;

   bit_framer6 #(.WIDTH(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .flush      (flush),
      .clr_ovf    (clr_ovf),
      .out_ready  (out_ready),
      .data_out   (data_out),
      .data_valid (data_valid),
      .bit_cnt    (bit_cnt),
      .overflow   (overflow),
      .word_cnt   (word_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_bits.delete();
      m_valid = 1'b0;
      m_data  = 0;
      m_ovf   = 1'b0;
      m_wcnt  = 0;
   endtask

   // One clock edge of the framer described in terms of bits, words and a slot.
   task automatic model_edge();
      bit complete = 0;
      int w = 0;
      if (flush) begin
         m_bits.delete();
      end else if (bit_valid) begin
         m_bits.push_back(int'(bit_in));
         if (m_bits.size() == 6) begin
            foreach (m_bits[i]) w = w * 2 + m_bits[i];
            m_bits.delete();
            complete = 1;
         end
      end
      if (clr_ovf) m_ovf = 1'b0;
      if (complete) begin
         if (!m_valid || out_ready) begin
            m_data  = w;
            m_valid = 1'b1;
            m_wcnt  = (m_wcnt + 1) % 256;
         end else begin
            m_ovf = 1'b1;
         end
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   function automatic logic [18:0] exp_vec();
      return {6'(m_data), m_valid, 3'(m_bits.size()), m_ovf, 8'(m_wcnt)};
   endfunction

   function automatic logic [18:0] got_vec();
      return {data_out, data_valid, bit_cnt, overflow, word_cnt};
   endfunction

   task automatic tick(input logic b, input logic v, input logic f, input logic c, input logic r);
      bit_in    = b;
      bit_valid = v;
      flush     = f;
      clr_ovf   = c;
      out_ready = r;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      bit_valid = 1'b0;
      flush     = 1'b0;
      clr_ovf   = 1'b0;
      out_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic send_word(input logic [5:0] w, input logic r_last, input logic r_rest);
      for (int i = 5; i >= 0; i--) tick(w[i], 1'b1, 1'b0, 1'b0, (i == 0) ? r_last : r_rest);
   endtask

   task automatic test_reset();
      model_reset();
      rst = 1'b1;
      bit_valid = 1'b1;
      bit_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (got_vec() !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=%h", got_vec(), 19'd0);
      end
      rst = 1'b0;
      bit_valid = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (got_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL reset_idle got=%h exp=%h", got_vec(), exp_vec());
      end
   endtask

   task automatic test_basic();
      logic [5:0] w = 6'b101010;
      do_reset();
      for (int i = 5; i >= 0; i--) begin
         tick(w[i], 1'b1, 1'b0, 1'b0, 1'b1);
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL basic_step%0d got=%h exp=%h", 5 - i, got_vec(), exp_vec());
         end
         if (i == 1) begin
            checks++;
            if (data_valid !== 1'b0) begin
               errors++;
               $display("FAIL basic_latency data_valid=%b exp=0", data_valid);
            end
         end
      end
      checks++;
      if ({data_out, data_valid, word_cnt} !== {6'b101010, 1'b1, 8'd1}) begin
         errors++;
         $display("FAIL basic_word data_out=%b valid=%b wcnt=%0d exp 101010/1/1", data_out, data_valid, word_cnt);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (data_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_one_cycle data_valid=%b exp=0", data_valid);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      send_word(6'b101100, 1'b0, 1'b0);
      send_word(6'b011011, 1'b0, 1'b0);
      checks++;
      if ({data_out, data_valid, overflow, word_cnt} !== {6'b101100, 1'b1, 1'b1, 8'd1}) begin
         errors++;
         $display("FAIL ovf_drop data_out=%b valid=%b ovf=%b wcnt=%0d exp 101100/1/1/1", data_out, data_valid, overflow, word_cnt);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (overflow !== 1'b0 || got_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL ovf_clear ovf=%b got=%h exp=%h", overflow, got_vec(), exp_vec());
      end
      for (int i = 5; i >= 1; i--) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (overflow !== 1'b1 || got_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL ovf_set_wins ovf=%b got=%h exp=%h", overflow, got_vec(), exp_vec());
      end
   endtask

   task automatic test_flush();
      do_reset();
      repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bit_cnt !== 3'd0 || got_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL flush_cnt bit_cnt=%0d got=%h exp=%h", bit_cnt, got_vec(), exp_vec());
      end
      send_word(6'b000111, 1'b0, 1'b0);
      checks++;
      if ({data_out, bit_cnt, data_valid} !== {6'b000111, 3'd0, 1'b1}) begin
         errors++;
         $display("FAIL flush_word data_out=%b bit_cnt=%0d valid=%b exp 000111/0/1", data_out, bit_cnt, data_valid);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_word(6'b101101, 1'b0, 1'b0);
      send_word(6'b111000, 1'b1, 1'b0);
      checks++;
      if ({data_out, data_valid, overflow, word_cnt} !== {6'b111000, 1'b1, 1'b0, 8'd2}) begin
         errors++;
         $display("FAIL b2b data_out=%b valid=%b ovf=%b wcnt=%0d exp 111000/1/0/2", data_out, data_valid, overflow, word_cnt);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      send_word(6'b101101, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      bit_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (got_vec() !== 19'd0) begin
         errors++;
         $display("FAIL async_reset got=%h exp=%h", got_vec(), 19'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      send_word(6'b101111, 1'b0, 1'b0);
      checks++;
      if ({data_out, data_valid, word_cnt} !== {6'b101111, 1'b1, 8'd1}) begin
         errors++;
         $display("FAIL async_after data_out=%b valid=%b wcnt=%0d exp 101111/1/1", data_out, data_valid, word_cnt);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int n = 1; n <= 257; n++) begin
         send_word(6'($urandom_range(0, 63)), 1'b1, 1'b1);
         if (n == 256) begin
            checks++;
            if (word_cnt !== 8'd0) begin
               errors++;
               $display("FAIL wrap_256 word_cnt=%0d exp=0", word_cnt);
            end
         end
         if (n % 64 == 0) begin
            checks++;
            if (got_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL wrap_word%0d got=%h exp=%h", n, got_vec(), exp_vec());
            end
         end
      end
      checks++;
      if (word_cnt !== 8'd1) begin
         errors++;
         $display("FAIL wrap_257 word_cnt=%0d exp=1", word_cnt);
      end
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         tick(1'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 4));
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            bad++;
            if (bad <= 10) $display("FAIL random_cycle%0d got=%h exp=%h", i, got_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_flush();
      test_back_to_back();
      test_async_reset();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
